// File: rtl/cpu_token_dispatcher.sv
// Token dispatcher for the shared external bus.
// The token is offered to one CPU bridge at a time. When that bridge acks, it
// holds the grant until it lets go, and then the offer moves round-robin to the
// next bridge. Two timeouts keep the bus moving: a bridge that never acks is
// skipped, and a bridge that holds too long has the grant revoked.
//
// Handshake: ext_next_cpu_q is the offer. It stays high for the whole offer
// and hold period, and ext_cpu_index is stable while it is high. The addressed
// bridge raises ext_next_cpu_e to take the token and keeps it high while it
// holds the token. Dropping ext_next_cpu_e releases the token. Only a clean
// 1'b1 counts on either input, so an undriven (z) or unknown (x) bus reads as 0.
module cpu_token_dispatcher #(
  parameter int NUM_CPUS = 4,
  parameter int IDX_W    = 32,
  parameter int ACK_TMO  = 16,
  parameter int HOLD_MAX = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_dispatcher_q,
  input  logic             ext_next_cpu_e,
  output logic [IDX_W-1:0] ext_cpu_index,
  output logic             ext_next_cpu_q,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_index,
  output logic             tmo_err,
  output logic [IDX_W-1:0] tmo_index
);

  localparam int PTR_W   = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
  localparam int CNT_MAX = (ACK_TMO > HOLD_MAX) ? ACK_TMO : HOLD_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OFFER   = 3'd1,
    ST_GRANT   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  // The current state is kept in a named signal so that checkers can bind to it.
  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             req;
  logic             ack;

  // Only a clean 1 on a bus line counts. Anything else (0, z, x) is treated as 0.
  assign req = (ext_dispatcher_q === 1'b1);
  assign ack = (ext_next_cpu_e === 1'b1);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_CPUS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Token FSM. Every output is registered and changes one cycle after the
  // edge that decides it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      cnt            <= '0;
      ext_cpu_index  <= '0;
      ext_next_cpu_q <= 1'b0;
      grant_valid    <= 1'b0;
      grant_index    <= '0;
      tmo_err        <= 1'b0;
      tmo_index      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ext_next_cpu_q <= 1'b0;
          if (req) begin
            state          <= ST_OFFER;
            ext_cpu_index  <= IDX_W'(ptr);
            ext_next_cpu_q <= 1'b1;
            cnt            <= '0;
          end
        end
        ST_OFFER: begin
          // When an ack arrives in the same cycle as the ack deadline, the ack wins.
          if (ack) begin
            state       <= ST_GRANT;
            grant_valid <= 1'b1;
            grant_index <= IDX_W'(ptr);
            cnt         <= '0;
          end else if (cnt == CNT_W'(ACK_TMO - 1)) begin
            // The CPU is dead or absent: record it, skip it, and keep the bus moving.
            state          <= ST_IDLE;
            tmo_err        <= 1'b1;
            tmo_index      <= IDX_W'(ptr);
            ptr            <= next_ptr(ptr);
            ext_next_cpu_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GRANT: begin
          // The offer strobe stays high so the holder keeps seeing its index.
          // When the release comes in the same cycle as the hold limit, it is a
          // normal release. Deasserting here lets the holder see q==0 on the
          // cycle after the release or revoke.
          if (!ack) begin
            state          <= ST_RELEASE;
            ext_next_cpu_q <= 1'b0;
            grant_valid    <= 1'b0;
          end else if (cnt == CNT_W'(HOLD_MAX - 1)) begin
            state          <= ST_RELEASE;
            tmo_err        <= 1'b1;
            tmo_index      <= IDX_W'(ptr);
            ext_next_cpu_q <= 1'b0;
            grant_valid    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          ext_next_cpu_q <= 1'b0;
          grant_valid    <= 1'b0;
          ptr            <= next_ptr(ptr);
          state          <= ST_GAP;
        end
        ST_GAP: begin
          // One quiet cycle, so the old holder has dropped out before a new index appears.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_token_dispatcher.sv
// Directed testbench for cpu_token_dispatcher with the default parameters:
// 4 CPUs, ack timeout of 16 cycles, hold limit of 256 cycles.
module tb_cpu_token_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_q = 1'b0;
  logic        next_e = 1'b0;
  logic [31:0] cpu_index;
  logic        next_q;
  logic        gnt_valid;
  logic [31:0] gnt_index;
  logic        tmo_err;
  logic [31:0] tmo_index;

  int n_vec = 0;
  int n_err = 0;

  cpu_token_dispatcher dut (
    .clk              (clk),
    .rst              (rst),
    .ext_dispatcher_q (disp_q),
    .ext_next_cpu_e   (next_e),
    .ext_cpu_index    (cpu_index),
    .ext_next_cpu_q   (next_q),
    .grant_valid      (gnt_valid),
    .grant_index      (gnt_index),
    .tmo_err          (tmo_err),
    .tmo_index        (tmo_index)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks. Inputs are driven, and outputs sampled, 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    disp_q = 1'b0;
    next_e = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Returns how many edges passed before the offer strobe was seen. A value of
  // 0 means no offer appeared within 20 edges.
  task automatic wait_offer(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (next_q === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Lets the currently offered CPU take the token for one cycle, then release it.
  task automatic serve();
    int n;
    wait_offer(n);
    n_vec++;
    if (n == 0) begin
      n_err++;
      $display("FAIL serve_offer: no offer within 20 cycles, required one");
    end
    next_e = 1'b1;
    tick();
    next_e = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    n_vec++;
    if ({next_q, gnt_valid, tmo_err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: q/gv/tmo=%b required 000", {next_q, gnt_valid, tmo_err});
    end
    n_vec++;
    if ({cpu_index, gnt_index, tmo_index} !== 96'd0) begin
      n_err++;
      $display("FAIL reset_idx: idx=%0d gi=%0d ti=%0d required 0", cpu_index, gnt_index, tmo_index);
    end
    // Move ptr to 1, and then hit reset in the middle of the offer to CPU1.
    disp_q = 1'b1;
    serve();
    wait_offer(n);
    n_vec++;
    if (cpu_index !== 32'd1) begin
      n_err++;
      $display("FAIL reset_pre_offer: idx=%0d required 1", cpu_index);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({next_q, gnt_valid, cpu_index} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_async_offer: q=%b gv=%b idx=%0d required all 0", next_q, gnt_valid, cpu_index);
    end
    tick();
    rst    = 1'b1;
    disp_q = 1'b0;
    tick();
    n_vec++;
    if (next_q !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_after: q=%b required 0", next_q);
    end
    // A reset during a grant also returns ptr to 0.
    disp_q = 1'b1;
    wait_offer(n);
    n_vec++;
    if (cpu_index !== 32'd0) begin
      n_err++;
      $display("FAIL reset_ptr_zero: idx=%0d required 0", cpu_index);
    end
    next_e = 1'b1;
    tick();
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({gnt_valid, next_q} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_async_grant: gv/q=%b required 00", {gnt_valid, next_q});
    end
    do_reset();
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    disp_q = 1'b1;
    wait_offer(n);
    n_vec++;
    if (n != 1 || cpu_index !== 32'd0) begin
      n_err++;
      $display("FAIL basic_offer: latency=%0d idx=%0d required 1 and 0", n, cpu_index);
    end
    tick();
    tick();
    n_vec++;
    if (gnt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_no_early_grant: gv=%b required 0", gnt_valid);
    end
    next_e = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({gnt_valid, gnt_index} !== {1'b1, 32'd0}) begin
        n_err++;
        $display("FAIL basic_hold[%0d]: gv=%b gi=%0d required 1 and 0", i, gnt_valid, gnt_index);
      end
      if (i == 4) next_e = 1'b0;
      tick();
    end
    n_vec++;
    if ({gnt_valid, next_q} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_release: gv/q=%b required 00", {gnt_valid, next_q});
    end
    wait_offer(n);
    n_vec++;
    if (n != 3 || cpu_index !== 32'd1) begin
      n_err++;
      $display("FAIL basic_next_offer: latency=%0d idx=%0d required 3 and 1", n, cpu_index);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    disp_q = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_offer(n);
      n_vec++;
      if (cpu_index !== 32'(exp_seq[k]) || n != ((k == 0) ? 1 : 3)) begin
        n_err++;
        $display("FAIL rr_offer[%0d]: idx=%0d latency=%0d required %0d and %0d",
                 k, cpu_index, n, exp_seq[k], (k == 0) ? 1 : 3);
      end
      next_e = 1'b1;
      tick();
      n_vec++;
      if ({gnt_valid, gnt_index} !== {1'b1, 32'(exp_seq[k])}) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: gv=%b gi=%0d required 1 and %0d", k, gnt_valid, gnt_index, exp_seq[k]);
      end
      next_e = 1'b0;
      tick();
      n_vec++;
      if ({gnt_valid, next_q} !== 2'b00) begin
        n_err++;
        $display("FAIL rr_release[%0d]: gv/q=%b required 00", k, {gnt_valid, next_q});
      end
    end
  endtask

  task automatic test_dead_cpu();
    int n;
    do_reset();
    disp_q = 1'b1;
    serve();
    serve();
    wait_offer(n);
    n_vec++;
    if (cpu_index !== 32'd2) begin
      n_err++;
      $display("FAIL dead_offer: idx=%0d required 2", cpu_index);
    end
    for (int i = 0; i < 15; i++) tick();
    n_vec++;
    if ({next_q, tmo_err} !== 2'b10) begin
      n_err++;
      $display("FAIL dead_before_tmo: q/tmo=%b required 10", {next_q, tmo_err});
    end
    tick();
    n_vec++;
    if ({next_q, tmo_err, tmo_index} !== {2'b01, 32'd2}) begin
      n_err++;
      $display("FAIL dead_tmo: q=%b tmo=%b ti=%0d required 0,1,2", next_q, tmo_err, tmo_index);
    end
    tick();
    n_vec++;
    if ({next_q, cpu_index} !== {1'b1, 32'd3}) begin
      n_err++;
      $display("FAIL dead_skip: q=%b idx=%0d required 1 and 3", next_q, cpu_index);
    end
    next_e = 1'b1;
    tick();
    n_vec++;
    if ({gnt_valid, gnt_index, tmo_err} !== {1'b1, 32'd3, 1'b1}) begin
      n_err++;
      $display("FAIL dead_not_stalled: gv=%b gi=%0d tmo=%b required 1,3,1", gnt_valid, gnt_index, tmo_err);
    end
    next_e = 1'b0;
    tick();
  endtask

  task automatic test_ack_deadline();
    int n;
    do_reset();
    disp_q = 1'b1;
    wait_offer(n);
    for (int i = 0; i < 15; i++) tick();
    next_e = 1'b1;
    tick();
    n_vec++;
    if ({gnt_valid, tmo_err} !== 2'b10) begin
      n_err++;
      $display("FAIL ack_tie: gv/tmo=%b required 10", {gnt_valid, tmo_err});
    end
    next_e = 1'b0;
    tick();
  endtask

  task automatic test_hog();
    int n;
    do_reset();
    disp_q = 1'b1;
    serve();
    wait_offer(n);
    next_e = 1'b1;
    tick();
    n_vec++;
    if ({gnt_valid, gnt_index} !== {1'b1, 32'd1}) begin
      n_err++;
      $display("FAIL hog_grant: gv=%b gi=%0d required 1 and 1", gnt_valid, gnt_index);
    end
    for (int i = 0; i < 255; i++) tick();
    n_vec++;
    if ({gnt_valid, next_q, tmo_err} !== 3'b110) begin
      n_err++;
      $display("FAIL hog_before_limit: gv/q/tmo=%b required 110", {gnt_valid, next_q, tmo_err});
    end
    tick();
    n_vec++;
    if ({gnt_valid, next_q, tmo_err, tmo_index} !== {3'b001, 32'd1}) begin
      n_err++;
      $display("FAIL hog_revoke: gv=%b q=%b tmo=%b ti=%0d required 0,0,1,1",
               gnt_valid, next_q, tmo_err, tmo_index);
    end
    // The revoked bridge sees q==0 and lets go. Rotation continues from CPU2.
    next_e = 1'b0;
    wait_offer(n);
    n_vec++;
    if (n != 3 || cpu_index !== 32'd2) begin
      n_err++;
      $display("FAIL hog_next_offer: latency=%0d idx=%0d required 3 and 2", n, cpu_index);
    end
  endtask

  task automatic test_hold_deadline();
    int n;
    do_reset();
    disp_q = 1'b1;
    wait_offer(n);
    next_e = 1'b1;
    tick();
    for (int i = 0; i < 255; i++) tick();
    next_e = 1'b0;
    tick();
    n_vec++;
    if ({gnt_valid, next_q, tmo_err} !== 3'b000) begin
      n_err++;
      $display("FAIL hold_tie: gv/q/tmo=%b required 000", {gnt_valid, next_q, tmo_err});
    end
  endtask

  task automatic test_z_inputs();
    do_reset();
    // Both bus lines are left undriven.
    disp_q = 1'bz;
    next_e = 1'bz;
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if ({next_q, gnt_valid, tmo_err} !== 3'b000) begin
      n_err++;
      $display("FAIL z_inputs: q/gv/tmo=%b required 000", {next_q, gnt_valid, tmo_err});
    end
    disp_q = 1'b0;
    next_e = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_dead_cpu();
    test_ack_deadline();
    test_hog();
    test_hold_deadline();
    test_z_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
